// File: rtl/tlt_req_arbiter.sv
// tlt_req_arbiter: round-robin arbiter merging NUM_REQ requesters onto one
// tagged downstream channel, allocating IDs and routing responses back.
// Ports: clock/reset (async active-low); in_valid/in_ready/in_addr/in_data/
// in_is_write/in_done per requester; rsp_valid/rsp_data routed response;
// tlt_req_* registered downstream request; tlt_resp_* downstream response;
// done aggregate completion; err sticky protocol error.
// Optional: define TLT_ARB_WATCHDOG_EN for per-ID 16-bit age watchdog.
module tlt_req_arbiter #(
    parameter int ADDR_BITS    = 32,
    parameter int DATA_BITS    = 32,
    parameter int ID_BITS      = 4,
    parameter int MAX_INFLIGHT = 8,
    parameter int NUM_REQ      = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            in_valid,
    output logic [NUM_REQ-1:0]            in_ready,
    input  logic [NUM_REQ*ADDR_BITS-1:0]  in_addr,
    input  logic [NUM_REQ*DATA_BITS-1:0]  in_data,
    input  logic [NUM_REQ-1:0]            in_is_write,
    input  logic [NUM_REQ-1:0]            in_done,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_BITS-1:0]          rsp_data,
    output logic                          tlt_req_valid,
    input  logic                          tlt_req_ready,
    output logic [ADDR_BITS-1:0]          tlt_req_bits_addr,
    output logic [DATA_BITS-1:0]          tlt_req_bits_data,
    output logic [ID_BITS-1:0]            tlt_req_bits_id,
    output logic                          tlt_req_bits_is_write,
    input  logic                          tlt_resp_valid,
    input  logic [DATA_BITS-1:0]          tlt_resp_bits_data,
    input  logic [ID_BITS-1:0]            tlt_resp_bits_id,
    output logic                          done,
    output logic                          err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic                    req_valid_q, req_valid_d;
    logic [ADDR_BITS-1:0]    req_addr_q, req_addr_d;
    logic [DATA_BITS-1:0]    req_data_q, req_data_d;
    logic [ID_BITS-1:0]      req_id_q, req_id_d;
    logic                    req_wr_q, req_wr_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [MAX_INFLIGHT-1:0] busy_q, busy_d;
    logic [IDX_W-1:0]        owner_q [MAX_INFLIGHT];
    logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic [DATA_BITS-1:0]    rsp_data_q, rsp_data_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;

    logic                    win_found;
    logic [IDX_W-1:0]        win_idx;
    logic [IDX_W-1:0]        cand;
    logic                    free_found;
    logic [ID_BITS-1:0]      alloc_id;
    logic [MAX_INFLIGHT-1:0] alloc_oh;
    logic                    resp_hit;
    logic [MAX_INFLIGHT-1:0] resp_oh;
    logic [IDX_W-1:0]        resp_owner;
    logic                    can_load;
    logic                    grant;
    logic [ADDR_BITS-1:0]    sel_addr;
    logic [DATA_BITS-1:0]    sel_data;
    logic                    sel_wr;
    logic                    wd_hit;

    // Round-robin search starting at the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!win_found && in_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_wr   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == IDX_W'(i)) begin
                sel_addr = in_addr[i*ADDR_BITS +: ADDR_BITS];
                sel_data = in_data[i*DATA_BITS +: DATA_BITS];
                sel_wr   = in_is_write[i];
            end
        end
    end

    // Lowest free ID, taken from the pre-response table so an ID freed
    // this cycle only becomes allocatable next cycle.
    always_comb begin
        free_found = 1'b0;
        alloc_id   = '0;
        alloc_oh   = '0;
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            if (!free_found && !busy_q[i]) begin
                free_found  = 1'b1;
                alloc_id    = ID_BITS'(i);
                alloc_oh[i] = 1'b1;
            end
        end
    end

    // Out-of-range IDs never match any table entry and so count as errors.
    always_comb begin
        resp_hit   = 1'b0;
        resp_oh    = '0;
        resp_owner = '0;
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            if (tlt_resp_valid && busy_q[i] &&
                tlt_resp_bits_id == ID_BITS'(i)) begin
                resp_hit   = 1'b1;
                resp_oh[i] = 1'b1;
                resp_owner = owner_q[i];
            end
        end
    end

    assign can_load = !req_valid_q || tlt_req_ready;
    assign grant    = reset && can_load && free_found && win_found;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            in_ready[i] = grant && (win_idx == IDX_W'(i));
        end
    end

    always_comb begin
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        req_id_d    = req_id_q;
        req_wr_d    = req_wr_q;
        ptr_d       = ptr_q;
        if (grant) begin
            req_valid_d = 1'b1;
            req_addr_d  = sel_addr;
            req_data_d  = sel_data;
            req_id_d    = alloc_id;
            req_wr_d    = sel_wr;
            if (win_idx == IDX_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_idx + 1'b1;
            end
        end else if (tlt_req_ready) begin
            req_valid_d = 1'b0;
        end
    end

    always_comb begin
        busy_d = busy_q & ~resp_oh;
        if (grant) begin
            busy_d = busy_d | alloc_oh;
        end
        rsp_valid_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid_d[i] = resp_hit && (resp_owner == IDX_W'(i));
        end
        rsp_data_d = resp_hit ? tlt_resp_bits_data : rsp_data_q;
        err_d  = err_q || (tlt_resp_valid && !resp_hit) || wd_hit;
        done_d = (&in_done) && (busy_d == '0) && !req_valid_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            req_id_q    <= '0;
            req_wr_q    <= 1'b0;
            ptr_q       <= '0;
            busy_q      <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                owner_q[i] <= '0;
            end
        end else begin
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            req_id_q    <= req_id_d;
            req_wr_q    <= req_wr_d;
            ptr_q       <= ptr_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            err_q       <= err_d;
            done_q      <= done_d;
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                if (grant && alloc_oh[i]) begin
                    owner_q[i] <= win_idx;
                end
            end
        end
    end

`ifdef TLT_ARB_WATCHDOG_EN
    logic [15:0] age_q [MAX_INFLIGHT];

    always_comb begin
        wd_hit = 1'b0;
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            if (busy_q[i] && age_q[i] == 16'hFFFF) begin
                wd_hit = 1'b1;
            end
        end
    end

    // Age restarts on allocation and saturates at all-ones.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                if (grant && alloc_oh[i]) begin
                    age_q[i] <= '0;
                end else if (!busy_q[i]) begin
                    age_q[i] <= '0;
                end else if (age_q[i] != 16'hFFFF) begin
                    age_q[i] <= age_q[i] + 16'd1;
                end
            end
        end
    end
`else
    assign wd_hit = 1'b0;
`endif

    assign tlt_req_valid         = req_valid_q;
    assign tlt_req_bits_addr     = req_addr_q;
    assign tlt_req_bits_data     = req_data_q;
    assign tlt_req_bits_id       = req_id_q;
    assign tlt_req_bits_is_write = req_wr_q;
    assign rsp_valid             = rsp_valid_q;
    assign rsp_data              = rsp_data_q;
    assign err                   = err_q;
    assign done                  = done_q;

endmodule

// File: tb/tb_tlt_req_arbiter.sv
// tb_tlt_req_arbiter: directed bench for tlt_req_arbiter with a
// behavioural reference model compared every cycle.
module tb_tlt_req_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int IW = 4;
    localparam int MI = 4;
    localparam int N  = 3;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_ready;
    logic [N*AW-1:0] in_addr = {8'h32, 8'h21, 8'h10};
    logic [N*DW-1:0] in_data = {8'hC2, 8'hB1, 8'hA0};
    logic [N-1:0]    in_is_write = 3'b101;
    logic [N-1:0]    in_done = '0;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            tlt_req_valid;
    logic            tlt_req_ready = 1'b1;
    logic [AW-1:0]   tlt_req_bits_addr;
    logic [DW-1:0]   tlt_req_bits_data;
    logic [IW-1:0]   tlt_req_bits_id;
    logic            tlt_req_bits_is_write;
    logic            tlt_resp_valid = 1'b0;
    logic [DW-1:0]   tlt_resp_bits_data = '0;
    logic [IW-1:0]   tlt_resp_bits_id = '0;
    logic            done;
    logic            err;

    always #5 clock = ~clock;

    tlt_req_arbiter #(
        .ADDR_BITS(AW), .DATA_BITS(DW), .ID_BITS(IW),
        .MAX_INFLIGHT(MI), .NUM_REQ(N)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data),
        .in_is_write(in_is_write), .in_done(in_done),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .tlt_req_valid(tlt_req_valid), .tlt_req_ready(tlt_req_ready),
        .tlt_req_bits_addr(tlt_req_bits_addr),
        .tlt_req_bits_data(tlt_req_bits_data),
        .tlt_req_bits_id(tlt_req_bits_id),
        .tlt_req_bits_is_write(tlt_req_bits_is_write),
        .tlt_resp_valid(tlt_resp_valid),
        .tlt_resp_bits_data(tlt_resp_bits_data),
        .tlt_resp_bits_id(tlt_resp_bits_id),
        .done(done), .err(err)
    );

    int total = 0;
    int bad   = 0;
    int acc_q[$];
    int gnt_q[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int qacc(input int i);
        if (i < acc_q.size()) return acc_q[i];
        return -1;
    endfunction

    function automatic int qgnt(input int i);
        if (i < gnt_q.size()) return gnt_q[i];
        return -1;
    endfunction

    // Reference model: ID pool, owner list, output slot, pending response.
    int            m_ptr = 0;
    bit            m_busy [MI];
    int            m_owner [MI];
    bit            m_ov = 1'b0;
    logic [AW-1:0] m_oaddr = '0;
    logic [DW-1:0] m_odata = '0;
    logic [IW-1:0] m_oid = '0;
    logic          m_owr = 1'b0;
    logic [N-1:0]  m_rv = '0;
    logic [DW-1:0] m_rdata = '0;
    bit            m_err = 1'b0;
    bit            m_done = 1'b0;

    function automatic int m_pick();
        bit any_free;
        any_free = 1'b0;
        if (!reset) return -1;
        if (m_ov && !tlt_req_ready) return -1;
        for (int i = 0; i < MI; i++) if (!m_busy[i]) any_free = 1'b1;
        if (!any_free) return -1;
        for (int k = 0; k < N; k++)
            if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    always @(posedge clock or negedge reset) begin : model
        int w;
        int fid;
        int rid;
        bit hit;
        bit idle;
        if (!reset) begin
            m_ptr = 0;
            for (int i = 0; i < MI; i++) begin
                m_busy[i] = 1'b0;
                m_owner[i] = 0;
            end
            m_ov = 1'b0; m_oaddr = '0; m_odata = '0;
            m_oid = '0; m_owr = 1'b0;
            m_rv = '0; m_rdata = '0;
            m_err = 1'b0; m_done = 1'b0;
        end else begin
            w = m_pick();
            fid = -1;
            for (int i = MI - 1; i >= 0; i--) if (!m_busy[i]) fid = i;
            rid = int'(tlt_resp_bits_id);
            hit = tlt_resp_valid && (rid < MI) && m_busy[rid];
            m_rv = '0;
            if (hit) begin
                for (int i = 0; i < N; i++)
                    if (i == m_owner[rid]) m_rv[i] = 1'b1;
                m_rdata = tlt_resp_bits_data;
                m_busy[rid] = 1'b0;
            end else if (tlt_resp_valid) begin
                m_err = 1'b1;
            end
            if (w >= 0) begin
                m_busy[fid] = 1'b1;
                m_owner[fid] = w;
                m_ov = 1'b1;
                m_oaddr = in_addr[w*AW +: AW];
                m_odata = in_data[w*DW +: DW];
                m_owr = in_is_write[w];
                m_oid = IW'(fid);
                m_ptr = (w + 1) % N;
            end else if (tlt_req_ready) begin
                m_ov = 1'b0;
            end
            idle = 1'b1;
            for (int i = 0; i < MI; i++) if (m_busy[i]) idle = 1'b0;
            m_done = (&in_done) && idle && !m_ov;
        end
    end

    always @(negedge clock) begin : cmp
        int w;
        logic [N-1:0] er;
        w = m_pick();
        er = '0;
        for (int i = 0; i < N; i++) if (i == w) er[i] = 1'b1;
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("req_valid", 32'(tlt_req_valid), 32'(m_ov));
        if (m_ov || !reset) begin
            chk("req_addr", 32'(tlt_req_bits_addr), 32'(m_oaddr));
            chk("req_data", 32'(tlt_req_bits_data), 32'(m_odata));
            chk("req_id", 32'(tlt_req_bits_id), 32'(m_oid));
            chk("req_wr", 32'(tlt_req_bits_is_write), 32'(m_owr));
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        if (m_rv != '0) chk("rsp_data", 32'(rsp_data), 32'(m_rdata));
        chk("err", 32'(err), 32'(m_err));
        chk("done", 32'(done), 32'(m_done));
        if (tlt_req_valid && tlt_req_ready)
            acc_q.push_back(int'(tlt_req_bits_id));
        for (int i = 0; i < N; i++)
            if (in_ready[i]) gnt_q.push_back(i);
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic resp1(input int id, input logic [DW-1:0] d);
        tlt_resp_valid = 1'b1;
        tlt_resp_bits_id = IW'(id);
        tlt_resp_bits_data = d;
        step();
        tlt_resp_valid = 1'b0;
    endtask

    logic [AW-1:0] hold_addr;
    logic [IW-1:0] hold_id;

    initial begin
        #1 reset = 1'b0;
        step(2);
        // requests during reset are never accepted
        in_valid = 3'b111;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_req_valid", 32'(tlt_req_valid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        in_valid = '0;
        step();
        reset = 1'b1;

        // alternating grants with same-cycle downstream responses
        acc_q.delete();
        gnt_q.delete();
        in_valid = 3'b011;
        for (int c = 0; c < 6; c++) begin
            tlt_resp_valid = tlt_req_valid;
            tlt_resp_bits_id = tlt_req_bits_id;
            tlt_resp_bits_data = DW'(8'h60 + c);
            step();
        end
        in_valid = '0;
        for (int c = 0; c < 3; c++) begin
            tlt_resp_valid = tlt_req_valid;
            tlt_resp_bits_id = tlt_req_bits_id;
            tlt_resp_bits_data = DW'(8'h70 + c);
            step();
        end
        tlt_resp_valid = 1'b0;
        chk("rr_g0", 32'(qgnt(0)), 32'd0);
        chk("rr_g1", 32'(qgnt(1)), 32'd1);
        chk("rr_g2", 32'(qgnt(2)), 32'd0);
        chk("rr_g3", 32'(qgnt(3)), 32'd1);
        chk("rr_id0", 32'(qacc(0)), 32'd0);
        chk("rr_id1", 32'(qacc(1)), 32'd1);
        chk("rr_id2", 32'(qacc(2)), 32'd0);
        chk("rr_id3", 32'(qacc(3)), 32'd1);

        // exhaust the ID pool, then free ID 0
        acc_q.delete();
        in_valid = 3'b001;
        step(6);
        chk("full_id0", 32'(qacc(0)), 32'd0);
        chk("full_id1", 32'(qacc(1)), 32'd1);
        chk("full_id2", 32'(qacc(2)), 32'd2);
        chk("full_id3", 32'(qacc(3)), 32'd3);
        chk("full_in_ready", 32'(in_ready), 32'h0);
        tlt_resp_valid = 1'b1;
        tlt_resp_bits_id = 4'd0;
        tlt_resp_bits_data = 8'h5A;
        #1;
        chk("free_same_cyc", 32'(in_ready), 32'h0);
        step();
        tlt_resp_valid = 1'b0;
        #1;
        chk("free_next_cyc", 32'(in_ready), 32'h1);
        acc_q.delete();
        step(2);
        chk("reuse_id0", 32'(qacc(0)), 32'd0);
        in_valid = '0;
        for (int i = 1; i <= 4; i++) resp1(i % 4, DW'(8'h80 + i));
        step();

        // backpressure: output held stable, no new grant
        in_valid = 3'b010;
        tlt_req_ready = 1'b0;
        step();
        hold_addr = tlt_req_bits_addr;
        hold_id = tlt_req_bits_id;
        chk("bp_addr", 32'(hold_addr), 32'h21);
        chk("bp_data", 32'(tlt_req_bits_data), 32'hB1);
        chk("bp_wr", 32'(tlt_req_bits_is_write), 32'h0);
        chk("bp_id", 32'(hold_id), 32'h0);
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", 32'(tlt_req_valid), 32'h1);
            chk("bp_addr_hold", 32'(tlt_req_bits_addr), 32'(hold_addr));
            chk("bp_id_hold", 32'(tlt_req_bits_id), 32'(hold_id));
            chk("bp_no_grant", 32'(in_ready), 32'h0);
            step();
        end
        tlt_req_ready = 1'b1;
        in_valid = '0;
        step();
        resp1(0, 8'h99);
        step();

        // response for an unused ID
        in_valid = 3'b001;
        step();
        in_valid = '0;
        resp1(5, 8'hEE);
        #1;
        chk("bad_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("bad_err", 32'(err), 32'h1);
        step(3);
        chk("bad_err_held", 32'(err), 32'h1);
        resp1(0, 8'h3C);
        #1;
        chk("ok_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("ok_rsp_data", 32'(rsp_data), 32'h3C);

        // done follows the last response by one cycle
        in_done = 3'b111;
        in_valid = 3'b100;
        step();
        in_valid = '0;
        step(2);
        chk("done_busy", 32'(done), 32'h0);
        tlt_resp_valid = 1'b1;
        tlt_resp_bits_id = 4'd0;
        tlt_resp_bits_data = 8'h44;
        #1;
        chk("done_at_T", 32'(done), 32'h0);
        step();
        tlt_resp_valid = 1'b0;
        #1;
        chk("done_at_T1", 32'(done), 32'h1);
        chk("done_rsp_own", 32'(rsp_valid), 32'h4);
        in_done = '0;
        step();

        // asynchronous reset with three IDs outstanding
        in_valid = 3'b001;
        step(3);
        #2 reset = 1'b0;
        #1;
        chk("ar_req_valid", 32'(tlt_req_valid), 32'h0);
        chk("ar_in_ready", 32'(in_ready), 32'h0);
        chk("ar_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("ar_done", 32'(done), 32'h0);
        chk("ar_err", 32'(err), 32'h0);
        chk("ar_addr", 32'(tlt_req_bits_addr), 32'h0);
        step();
        reset = 1'b1;
        #1;
        chk("post_rst_rdy", 32'(in_ready), 32'h1);
        step();
        in_valid = '0;
        chk("post_rst_vld", 32'(tlt_req_valid), 32'h1);
        chk("post_rst_id", 32'(tlt_req_bits_id), 32'h0);
        resp1(1, 8'h11);
        #1;
        chk("stale_err", 32'(err), 32'h1);
        resp1(0, 8'h22);
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
